// File: rtl/ct_vfdsu_wb_buf_if.sv
// Writeback bundle between the VFDSU datapath, the register-file arbiter and the result buffer.
// The master side drives the requests and the grant. The slave side is the buffer.
interface ct_vfdsu_wb_buf_if;
  logic        rtu_yy_xx_flush;
  logic        vfdsu_dp_inst_wb_req;
  logic [63:0] pipex_dp_vfdsu_freg_data;
  logic [4:0]  pipex_dp_vfdsu_ereg_data;
  logic [4:0]  pipex_dp_vfdsu_ereg;
  logic [6:0]  pipex_dp_vfdsu_vreg;
  logic        rf_vfdsu_wb_grant;
  logic        vfdsu_rf_wb_vld;
  logic [63:0] vfdsu_rf_wb_data;
  logic [4:0]  vfdsu_rf_wb_expt;
  logic [4:0]  vfdsu_rf_wb_ereg;
  logic [6:0]  vfdsu_rf_wb_vreg;
  logic        vfdsu_wb_full;
  logic        vfdsu_wb_ovfl;
  logic [15:0] vfdsu_wb_stall_cnt;

  modport master (
    output rtu_yy_xx_flush, vfdsu_dp_inst_wb_req, pipex_dp_vfdsu_freg_data,
           pipex_dp_vfdsu_ereg_data, pipex_dp_vfdsu_ereg, pipex_dp_vfdsu_vreg, rf_vfdsu_wb_grant,
    input  vfdsu_rf_wb_vld, vfdsu_rf_wb_data, vfdsu_rf_wb_expt, vfdsu_rf_wb_ereg,
           vfdsu_rf_wb_vreg, vfdsu_wb_full, vfdsu_wb_ovfl, vfdsu_wb_stall_cnt
  );

  modport slave (
    input  rtu_yy_xx_flush, vfdsu_dp_inst_wb_req, pipex_dp_vfdsu_freg_data,
           pipex_dp_vfdsu_ereg_data, pipex_dp_vfdsu_ereg, pipex_dp_vfdsu_vreg, rf_vfdsu_wb_grant,
    output vfdsu_rf_wb_vld, vfdsu_rf_wb_data, vfdsu_rf_wb_expt, vfdsu_rf_wb_ereg,
           vfdsu_rf_wb_vreg, vfdsu_wb_full, vfdsu_wb_ovfl, vfdsu_wb_stall_cnt
  );
endinterface

// File: rtl/ct_vfdsu_wb_buf.sv
// Two-entry writeback FIFO for divide/sqrt results with overflow flag and stall counter.
// Optional VFDSU_WB_BYPASS_EN: an empty buffer forwards a request to the outputs in the same cycle.
module ct_vfdsu_wb_buf (
  input logic              forever_cpuclk,
  input logic              cpurst,
  ct_vfdsu_wb_buf_if.slave bus_io
);

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  expt;
    logic [4:0]  ereg;
    logic [6:0]  vreg;
  } entry_t;

  entry_t      mem_q [2];
  entry_t      in_entry;
  entry_t      out_entry;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        ovfl_q, ovfl_d;
  logic [15:0] stall_q, stall_d;
  logic        req, grant, flush;
  logic        buf_vld, byp_vld, out_vld;
  logic        pop, byp_take, push, drop;

  assign req   = bus_io.vfdsu_dp_inst_wb_req;
  assign grant = bus_io.rf_vfdsu_wb_grant;
  assign flush = bus_io.rtu_yy_xx_flush;

  assign in_entry = '{data: bus_io.pipex_dp_vfdsu_freg_data,
                      expt: bus_io.pipex_dp_vfdsu_ereg_data,
                      ereg: bus_io.pipex_dp_vfdsu_ereg,
                      vreg: bus_io.pipex_dp_vfdsu_vreg};

`ifdef VFDSU_WB_BYPASS_EN
  assign byp_vld = (cnt_q == 2'd0) & req & ~flush;
`else
  assign byp_vld = 1'b0;
`endif

  always_comb begin
    buf_vld   = (cnt_q != 2'd0);
    out_vld   = buf_vld | byp_vld;
    out_entry = '0;
    if (buf_vld) out_entry = mem_q[rd_ptr_q];
`ifdef VFDSU_WB_BYPASS_EN
    if (byp_vld) out_entry = in_entry;
`endif
    pop      = buf_vld & grant;
    // A granted bypass result is consumed straight from the inputs and never stored.
    byp_take = byp_vld & grant;
    push     = req & ~flush & ~byp_take & ((cnt_q != 2'd2) | pop);
    drop     = req & ~flush & (cnt_q == 2'd2) & ~pop;

    if (flush) begin
      cnt_d    = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
    end

    ovfl_d  = ovfl_q | drop;
    stall_d = stall_q;
    if (out_vld && !grant && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ovfl_q   <= 1'b0;
      stall_q  <= 16'd0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovfl_q   <= ovfl_d;
      stall_q  <= stall_d;
    end
  end

  // Payload storage is never reset; outputs are masked whenever nothing is valid.
  always_ff @(posedge forever_cpuclk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  assign bus_io.vfdsu_rf_wb_vld    = out_vld;
  assign bus_io.vfdsu_rf_wb_data   = out_entry.data;
  assign bus_io.vfdsu_rf_wb_expt   = out_entry.expt;
  assign bus_io.vfdsu_rf_wb_ereg   = out_entry.ereg;
  assign bus_io.vfdsu_rf_wb_vreg   = out_entry.vreg;
  assign bus_io.vfdsu_wb_full      = (cnt_q == 2'd2);
  assign bus_io.vfdsu_wb_ovfl      = ovfl_q;
  assign bus_io.vfdsu_wb_stall_cnt = stall_q;

endmodule

// File: tb/tb_ct_vfdsu_wb_buf.sv
// Bench for ct_vfdsu_wb_buf: directed vector table, hand-written reset/flush sequences and a
// randomized run checked against a queue-based reference model.
module tb_ct_vfdsu_wb_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ct_vfdsu_wb_buf_if bus ();

  ct_vfdsu_wb_buf dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bus_io         (bus)
  );

  always #5 clk = ~clk;

`ifdef VFDSU_WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  expt;
    logic [4:0]  ereg;
    logic [6:0]  vreg;
  } ent_t;

  typedef struct {
    logic        req, grant, flush;
    logic [63:0] data;
    logic [6:0]  vreg;
    logic        ev, ef, eo;
    logic [63:0] ed;
    logic [6:0]  evr;
    logic [15:0] es;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic req, input logic grant, input logic flush,
                        input logic [63:0] data, input logic [4:0] expt, input logic [4:0] ereg,
                        input logic [6:0] vreg);
    bus.vfdsu_dp_inst_wb_req     = req;
    bus.rf_vfdsu_wb_grant        = grant;
    bus.rtu_yy_xx_flush          = flush;
    bus.pipex_dp_vfdsu_freg_data = data;
    bus.pipex_dp_vfdsu_ereg_data = expt;
    bus.pipex_dp_vfdsu_ereg      = ereg;
    bus.pipex_dp_vfdsu_vreg      = vreg;
  endtask

  // Apply inputs just after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic req, input logic grant, input logic flush,
                       input logic [63:0] data, input logic [6:0] vreg);
    @(negedge clk);
    set_in(req, grant, flush, data, data[4:0] ^ 5'h0A, vreg[4:0], vreg);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"},   bus.vfdsu_rf_wb_vld, 1'b0);
    chk({tag, "_full"},  bus.vfdsu_wb_full, 1'b0);
    chk({tag, "_ovfl"},  bus.vfdsu_wb_ovfl, 1'b0);
    chk({tag, "_stall"}, bus.vfdsu_wb_stall_cnt, 16'd0);
    chk({tag, "_data"},  bus.vfdsu_rf_wb_data, 64'd0);
    chk({tag, "_tags"},  {bus.vfdsu_rf_wb_expt, bus.vfdsu_rf_wb_ereg, bus.vfdsu_rf_wb_vreg}, 17'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 64'd0, 5'd0, 5'd0, 7'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [63:0] DA = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] B1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] B2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] DC = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] DD = 64'hDDDD_EEEE_FFFF_0001;
  localparam logic [63:0] DE = 64'h0123_4567_89AB_CDEF;

  vec_t vt [18];
  ent_t q [$];
  ent_t in_e, exp_e;
  logic m_ovfl;
  logic [15:0] m_stall;
  logic r_req, r_grant, r_flush, hit, ev, taken;

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 64'd0, 5'd0, 5'd0, 7'd0);
    //          req gnt fl  data vreg   vld full ovfl exp_data vreg stall
    vt[0]  = '{0, 0, 0, 64'd0, 7'd0,  0, 0, 0, 64'd0, 7'd0,  16'd0};
    vt[1]  = '{1, 1, 0, DA,    7'd5,  0, 0, 0, 64'd0, 7'd0,  16'd0};
    vt[2]  = '{0, 1, 0, 64'd0, 7'd0,  1, 0, 0, DA,    7'd5,  16'd0};
    vt[3]  = '{0, 1, 0, 64'd0, 7'd0,  0, 0, 0, 64'd0, 7'd0,  16'd0};
    vt[4]  = '{1, 0, 0, B1,    7'd9,  0, 0, 0, 64'd0, 7'd0,  16'd0};
    vt[5]  = '{1, 0, 0, B2,    7'd10, 1, 0, 0, B1,    7'd9,  16'd0};
    vt[6]  = '{0, 0, 0, 64'd0, 7'd0,  1, 1, 0, B1,    7'd9,  16'd1};
    vt[7]  = '{0, 0, 0, 64'd0, 7'd0,  1, 1, 0, B1,    7'd9,  16'd2};
    vt[8]  = '{0, 0, 0, 64'd0, 7'd0,  1, 1, 0, B1,    7'd9,  16'd3};
    vt[9]  = '{0, 0, 0, 64'd0, 7'd0,  1, 1, 0, B1,    7'd9,  16'd4};
    vt[10] = '{0, 0, 0, 64'd0, 7'd0,  1, 1, 0, B1,    7'd9,  16'd5};
    vt[11] = '{1, 0, 0, DC,    7'd11, 1, 1, 0, B1,    7'd9,  16'd6};
    vt[12] = '{0, 0, 0, 64'd0, 7'd0,  1, 1, 1, B1,    7'd9,  16'd7};
    vt[13] = '{1, 1, 0, DD,    7'd12, 1, 1, 1, B1,    7'd9,  16'd8};
    vt[14] = '{0, 1, 0, 64'd0, 7'd0,  1, 1, 1, B2,    7'd10, 16'd8};
    vt[15] = '{0, 0, 0, 64'd0, 7'd0,  1, 0, 1, DD,    7'd12, 16'd8};
    vt[16] = '{1, 0, 1, DE,    7'd13, 1, 0, 1, DD,    7'd12, 16'd9};
    vt[17] = '{0, 0, 0, 64'd0, 7'd0,  0, 0, 1, 64'd0, 7'd0,  16'd10};

    // Outputs while reset is held.
    repeat (2) @(negedge clk);
    #1;
    chk_idle("in_reset");
    @(negedge clk);
    rst = 1'b0;

`ifndef VFDSU_WB_BYPASS_EN
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].req, vt[i].grant, vt[i].flush, vt[i].data, vt[i].vreg);
      chk($sformatf("vec%0d_vld", i),   bus.vfdsu_rf_wb_vld, vt[i].ev);
      chk($sformatf("vec%0d_full", i),  bus.vfdsu_wb_full, vt[i].ef);
      chk($sformatf("vec%0d_ovfl", i),  bus.vfdsu_wb_ovfl, vt[i].eo);
      chk($sformatf("vec%0d_data", i),  bus.vfdsu_rf_wb_data, vt[i].ed);
      chk($sformatf("vec%0d_vreg", i),  bus.vfdsu_rf_wb_vreg, vt[i].evr);
      chk($sformatf("vec%0d_stall", i), bus.vfdsu_wb_stall_cnt, vt[i].es);
    end
`endif

    // Asynchronous reset in the middle of a cycle with an entry pending and stall counting.
    drive(1'b1, 1'b0, 1'b0, DA, 7'd5);
    drive(1'b0, 1'b0, 1'b0, 64'd0, 7'd0);
    drive(1'b0, 1'b0, 1'b0, 64'd0, 7'd0);
    chk("pre_rst_vld", bus.vfdsu_rf_wb_vld, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 64'd0, 7'd0);
    drive(1'b0, 1'b1, 1'b0, 64'd0, 7'd0);
    chk_idle("post_rst");

    // Flush while full with a same-cycle request: everything discarded, no overflow.
    drive(1'b1, 1'b0, 1'b0, B1, 7'd9);
    drive(1'b1, 1'b0, 1'b0, B2, 7'd10);
    drive(1'b0, 1'b0, 1'b0, 64'd0, 7'd0);
    chk("fl_full_before", bus.vfdsu_wb_full, 1'b1);
    drive(1'b1, 1'b0, 1'b1, DC, 7'd11);
    drive(1'b0, 1'b1, 1'b0, 64'd0, 7'd0);
    chk("fl_vld_after",  bus.vfdsu_rf_wb_vld, 1'b0);
    chk("fl_full_after", bus.vfdsu_wb_full, 1'b0);
    chk("fl_ovfl_after", bus.vfdsu_wb_ovfl, 1'b0);
    chk("fl_data_after", bus.vfdsu_rf_wb_data, 64'd0);

    // Randomized run against a queue model of the buffer.
    do_reset();
    m_ovfl  = 1'b0;
    m_stall = 16'd0;
    q.delete();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r_req   = ($urandom_range(0, 1) == 1);
      r_grant = ($urandom_range(0, 2) != 0);
      r_flush = ($urandom_range(0, 19) == 0);
      in_e    = '{data: {$urandom, $urandom}, expt: 5'($urandom), ereg: 5'($urandom),
                  vreg: 7'($urandom)};
      set_in(r_req, r_grant, r_flush, in_e.data, in_e.expt, in_e.ereg, in_e.vreg);
      #1;
      hit   = Byp && (q.size() == 0) && r_req && !r_flush;
      ev    = (q.size() > 0) || hit;
      exp_e = hit ? in_e : ((q.size() > 0) ? q[0] : '0);
      chk("rnd_vld",   bus.vfdsu_rf_wb_vld, ev);
      chk("rnd_full",  bus.vfdsu_wb_full, q.size() == 2);
      chk("rnd_ovfl",  bus.vfdsu_wb_ovfl, m_ovfl);
      chk("rnd_stall", bus.vfdsu_wb_stall_cnt, m_stall);
      chk("rnd_data",  bus.vfdsu_rf_wb_data, exp_e.data);
      chk("rnd_tags",  {bus.vfdsu_rf_wb_expt, bus.vfdsu_rf_wb_ereg, bus.vfdsu_rf_wb_vreg},
          {exp_e.expt, exp_e.ereg, exp_e.vreg});
      if (ev && !r_grant && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (r_flush) begin
        q.delete();
      end else begin
        taken = 1'b0;
        if (ev && r_grant) begin
          if (hit) taken = 1'b1;
          else void'(q.pop_front());
        end
        if (r_req && !taken) begin
          if (q.size() < 2) q.push_back(in_e);
          else m_ovfl = 1'b1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
